// File: rtl/core_pkg.sv
// Shared encodings for the RV32I core: write-back select, data-memory access
// type, MEM-stage FSM states and an access-size decode helper.
package core_pkg;

    // Write-back mux select, shared with the write-back stage.
    localparam logic [1:0] WdselFromAlu = 2'b00;
    localparam logic [1:0] WdselFromMem = 2'b01;
    localparam logic [1:0] WdselFromPc  = 2'b10;

    // Data-memory access type (funct3 of the load/store).
    localparam logic [2:0] DmtLb  = 3'b000;
    localparam logic [2:0] DmtLh  = 3'b001;
    localparam logic [2:0] DmtLw  = 3'b010;
    localparam logic [2:0] DmtLbu = 3'b100;
    localparam logic [2:0] DmtLhu = 3'b101;

    typedef enum logic [1:0] {
        SzByte,
        SzHalf,
        SzWord
    } acc_size_e;

    typedef enum logic {
        IDLE,
        WAIT
    } mem_state_e;

    // Undefined encodings fall back to a word access.
    function automatic acc_size_e access_size(input logic [2:0] dmtype);
        case (dmtype)
            DmtLb, DmtLbu: return SzByte;
            DmtLh, DmtLhu: return SzHalf;
            default:       return SzWord;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/half lane of a read word and sign- or
// zero-extends it according to the load type.
module mem_load_align
    import core_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_dmtype,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    // Extend the selected lane; anything not byte/half passes the word through.
    always_comb begin
        o_data = i_rdata;
        case (i_dmtype)
            DmtLb:   o_data = {{24{w_byte[7]}}, w_byte};
            DmtLh:   o_data = {{16{w_half[15]}}, w_half};
            DmtLbu:  o_data = {24'b0, w_byte};
            DmtLhu:  o_data = {16'b0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage with the MEM/WB register: issues data-memory requests
// over a req/ack handshake, stalls the pipeline while the access is
// outstanding, and presents aligned load data to write-back.
module mem_stage
    import core_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        MEM_valid,
    input  logic [31:0] MEM_aluout,
    input  logic [31:0] MEM_rs2data,
    input  logic [31:0] MEM_PC,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic [2:0]  MEM_DMType,
    input  logic [1:0]  MEM_WDSel,
    input  logic [4:0]  MEM_rd,
    input  logic        MEM_RegWrite,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        misalign_exc,
    output logic        bus_err,
    output logic        WB_valid,
    output logic [31:0] WB_aluout,
    output logic [31:0] WB_Data_in,
    output logic [31:0] WB_PC,
    output logic [1:0]  WB_WDSel,
    output logic [4:0]  WB_rd,
    output logic        WB_RegWrite
);

    mem_state_e  r_state, w_state_d;
    logic [31:0] r_cnt;
    logic [2:0]  r_dmtype;
    logic [1:0]  r_lane;

    logic        w_access, w_misalign, w_timeout;
    logic        w_stall, w_issue, w_done, w_abort;
    acc_size_e   w_size;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_load_data;

    assign w_access   = MEM_valid & (MEM_MemRead | MEM_MemWrite);
    assign w_size     = access_size(MEM_DMType);
    assign w_misalign = ((w_size == SzHalf) & MEM_aluout[0]) |
                        ((w_size == SzWord) & (|MEM_aluout[1:0]));
    // Ack on the expiring cycle takes priority over the timeout.
    assign w_timeout  = (BUS_TIMEOUT != 0) && (r_state == WAIT) && !dmem_ack &&
                        (r_cnt == BUS_TIMEOUT - 1);
    assign mem_stall  = w_stall;

    // Store byte-enables and lane-replicated write data.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = MEM_rs2data;
        case (w_size)
            SzByte: begin
                w_be    = 4'b0001 << MEM_aluout[1:0];
                w_wdata = {4{MEM_rs2data[7:0]}};
            end
            SzHalf: begin
                w_be    = 4'b0011 << MEM_aluout[1:0];
                w_wdata = {2{MEM_rs2data[15:0]}};
            end
            default: ;
        endcase
    end

    mem_load_align u_load_align (
        .i_rdata   (dmem_rdata),
        .i_addr_lo (r_lane),
        .i_dmtype  (r_dmtype),
        .o_data    (w_load_data)
    );

    // Next-state and stall decode. A timeout also releases the stall so the
    // faulting instruction leaves EX/MEM instead of being re-issued.
    always_comb begin
        w_state_d = r_state;
        w_stall   = 1'b0;
        w_issue   = 1'b0;
        w_done    = 1'b0;
        w_abort   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_access && !w_misalign) begin
                    w_stall   = 1'b1;
                    w_issue   = 1'b1;
                    w_state_d = WAIT;
                end
            end
            WAIT: begin
                if (dmem_ack) begin
                    w_done    = 1'b1;
                    w_state_d = IDLE;
                end else if (w_timeout) begin
                    w_abort   = 1'b1;
                    w_state_d = IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    // FSM state and WAIT-cycle counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_issue) begin
                r_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
    end

    // Memory request register; held stable for the whole transaction.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_be    <= '0;
            r_dmtype   <= '0;
            r_lane     <= '0;
        end else if (w_issue) begin
            dmem_req   <= 1'b1;
            dmem_we    <= MEM_MemWrite;
            dmem_addr  <= {MEM_aluout[31:2], 2'b00};
            dmem_wdata <= w_wdata;
            dmem_be    <= w_be;
            r_dmtype   <= MEM_DMType;
            r_lane     <= MEM_aluout[1:0];
        end else if (w_done || w_abort) begin
            dmem_req <= 1'b0;
        end
    end

    // One-cycle exception pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            misalign_exc <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            misalign_exc <= (r_state == IDLE) & w_access & w_misalign;
            bus_err      <= w_abort;
        end
    end

    // MEM/WB register: retires non-memory ops from IDLE and memory ops on
    // ack; every other cycle loads a bubble so WB never writes twice.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            WB_valid    <= 1'b0;
            WB_aluout   <= '0;
            WB_Data_in  <= '0;
            WB_PC       <= '0;
            WB_WDSel    <= '0;
            WB_rd       <= '0;
            WB_RegWrite <= 1'b0;
        end else begin
            WB_aluout <= MEM_aluout;
            WB_PC     <= MEM_PC;
            WB_WDSel  <= MEM_WDSel;
            WB_rd     <= MEM_rd;
            if (r_state == WAIT) begin
                WB_valid    <= w_done;
                WB_RegWrite <= w_done & MEM_RegWrite;
                WB_Data_in  <= dmem_we ? 32'b0 : w_load_data;
            end else begin
                WB_valid    <= MEM_valid & ~w_access;
                WB_RegWrite <= MEM_valid & ~w_access & MEM_RegWrite;
                WB_Data_in  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by random
// instructions checked against a byte-level reference model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        MEM_valid, MEM_MemRead, MEM_MemWrite, MEM_RegWrite;
    logic [31:0] MEM_aluout, MEM_rs2data, MEM_PC;
    logic [2:0]  MEM_DMType;
    logic [1:0]  MEM_WDSel;
    logic [4:0]  MEM_rd;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        mem_stall, misalign_exc, bus_err;
    logic        WB_valid, WB_RegWrite;
    logic [31:0] WB_aluout, WB_Data_in, WB_PC;
    logic [1:0]  WB_WDSel;
    logic [4:0]  WB_rd;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_stage #(.BUS_TIMEOUT(4)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .MEM_valid    (MEM_valid),
        .MEM_aluout   (MEM_aluout),
        .MEM_rs2data  (MEM_rs2data),
        .MEM_PC       (MEM_PC),
        .MEM_MemRead  (MEM_MemRead),
        .MEM_MemWrite (MEM_MemWrite),
        .MEM_DMType   (MEM_DMType),
        .MEM_WDSel    (MEM_WDSel),
        .MEM_rd       (MEM_rd),
        .MEM_RegWrite (MEM_RegWrite),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_be      (dmem_be),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
        .mem_stall    (mem_stall),
        .misalign_exc (misalign_exc),
        .bus_err      (bus_err),
        .WB_valid     (WB_valid),
        .WB_aluout    (WB_aluout),
        .WB_Data_in   (WB_Data_in),
        .WB_PC        (WB_PC),
        .WB_WDSel     (WB_WDSel),
        .WB_rd        (WB_rd),
        .WB_RegWrite  (WB_RegWrite)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: access width in bytes, undefined types are words.
    function automatic int nbytes(input logic [2:0] t);
        case (t)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [31:0] load_ref(input logic [31:0] rdata, input int lane,
                                             input logic [2:0] t);
        logic [31:0] v, mask;
        int n;
        n = nbytes(t);
        if (n == 4) return rdata;
        mask = (32'd1 << (8 * n)) - 32'd1;
        v = (rdata >> (8 * lane)) & mask;
        if (!t[2] && v[8 * n - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] be_ref(input int lane, input int n);
        logic [7:0] b;
        b = 8'(((1 << n) - 1) << lane);
        return b[3:0];
    endfunction

    function automatic logic [31:0] wdata_ref(input logic [31:0] rs2, input int n);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8 * i +: 8] = rs2[8 * (i % n) +: 8];
        return w;
    endfunction

    task automatic drive(input logic v, input logic [31:0] addr, rs2, pc, input logic mr, mw,
                         input logic [2:0] dmt, input logic [4:0] rd, input logic rw,
                         input logic [1:0] wds);
        MEM_valid    = v;
        MEM_aluout   = addr;
        MEM_rs2data  = rs2;
        MEM_PC       = pc;
        MEM_MemRead  = mr;
        MEM_MemWrite = mw;
        MEM_DMType   = dmt;
        MEM_rd       = rd;
        MEM_RegWrite = rw;
        MEM_WDSel    = wds;
    endtask

    // Present one instruction (called just after an edge, FSM idle) and
    // follow it to retirement; memory acks on WAIT cycle 'lat'.
    task automatic run_instr(input logic v, input logic [31:0] addr, rs2, pc,
                             input logic mr, mw, input logic [2:0] dmt, input logic [4:0] rd,
                             input logic rw, input logic [1:0] wds, input int lat,
                             input logic [31:0] rdata);
        logic acc, mis;
        int   n, lane;
        drive(v, addr, rs2, pc, mr, mw, dmt, rd, rw, wds);
        dmem_ack = 1'b0;
        acc  = v & (mr | mw);
        n    = nbytes(dmt);
        lane = int'(addr[1:0]);
        mis  = acc && ((lane % n) != 0);
        #1;
        if (!acc || mis) begin
            chk("stall_none", {31'b0, mem_stall}, 32'd0);
            tick();
            chk("wb_valid", {31'b0, WB_valid}, {31'b0, v & ~acc});
            chk("wb_regwrite", {31'b0, WB_RegWrite}, {31'b0, v & ~acc & rw});
            chk("misalign_exc", {31'b0, misalign_exc}, {31'b0, mis});
            chk("no_req", {31'b0, dmem_req}, 32'd0);
            if (!acc) begin
                chk("wb_aluout", WB_aluout, addr);
                chk("wb_pc", WB_PC, pc);
                chk("wb_rd", {27'b0, WB_rd}, {27'b0, rd});
                chk("wb_wdsel", {30'b0, WB_WDSel}, {30'b0, wds});
                chk("wb_data_alu", WB_Data_in, 32'd0);
            end
        end else begin
            chk("stall_issue", {31'b0, mem_stall}, 32'd1);
            tick();
            chk("req_set", {31'b0, dmem_req}, 32'd1);
            chk("req_we", {31'b0, dmem_we}, {31'b0, mw});
            chk("req_addr", dmem_addr, {addr[31:2], 2'b00});
            if (mw) begin
                chk("req_be", {28'b0, dmem_be}, {28'b0, be_ref(lane, n)});
                chk("req_wdata", dmem_wdata, wdata_ref(rs2, n));
            end
            chk("bubble_valid", {31'b0, WB_valid}, 32'd0);
            chk("bubble_regwrite", {31'b0, WB_RegWrite}, 32'd0);
            for (int k = 1; k <= lat; k++) begin
                dmem_ack   = (k == lat);
                dmem_rdata = (k == lat) ? rdata : $urandom;
                #1;
                chk("stall_wait", {31'b0, mem_stall}, {31'b0, k != lat});
                tick();
                dmem_ack = 1'b0;
                if (k < lat) begin
                    chk("req_hold", {31'b0, dmem_req}, 32'd1);
                    chk("addr_hold", dmem_addr, {addr[31:2], 2'b00});
                    chk("bubble_wait", {31'b0, WB_RegWrite}, 32'd0);
                end
            end
            chk("req_drop", {31'b0, dmem_req}, 32'd0);
            chk("done_valid", {31'b0, WB_valid}, 32'd1);
            chk("done_regwrite", {31'b0, WB_RegWrite}, {31'b0, rw});
            chk("done_data", WB_Data_in, mw ? 32'd0 : load_ref(rdata, lane, dmt));
            chk("done_aluout", WB_aluout, addr);
            chk("done_pc", WB_PC, pc);
            chk("done_no_buserr", {31'b0, bus_err}, 32'd0);
        end
    endtask

    initial begin
        rstn       = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 3'b0, 5'd0, 1'b0, 2'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'b0, dmem_req}, 32'd0);
        chk("rst_wb_valid", {31'b0, WB_valid}, 32'd0);
        chk("rst_wb_data", WB_Data_in, 32'd0);
        chk("rst_exc", {30'b0, misalign_exc, bus_err}, 32'd0);
        chk("rst_stall", {31'b0, mem_stall}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // add, lb/lbu at 0x103, sh at 0x102
        run_instr(1, 32'h1234, 0, 32'h40, 0, 0, 3'b000, 5'd3, 1, 2'b00, 1, 0);
        run_instr(1, 32'h103, 0, 32'h44, 1, 0, 3'b000, 5'd4, 1, 2'b01, 3, 32'h80FF_EEDD);
        chk("lb_signext", WB_Data_in, 32'hFFFF_FF80);
        run_instr(1, 32'h103, 0, 32'h48, 1, 0, 3'b100, 5'd5, 1, 2'b01, 3, 32'h80FF_EEDD);
        chk("lbu_zeroext", WB_Data_in, 32'h0000_0080);
        run_instr(1, 32'h102, 32'hABCD_1234, 32'h4c, 0, 1, 3'b001, 5'd0, 0, 2'b00, 2, 0);

        // misaligned lw, then a normal instruction with no stall
        run_instr(1, 32'h101, 0, 32'h50, 1, 0, 3'b010, 5'd6, 1, 2'b01, 1, 0);
        run_instr(1, 32'h77, 0, 32'h54, 0, 0, 3'b000, 5'd7, 1, 2'b00, 1, 0);
        chk("misalign_one_cycle", {31'b0, misalign_exc}, 32'd0);

        // timeout: no ack for 4 WAIT cycles
        drive(1, 32'h200, 0, 32'h58, 1, 0, 3'b010, 5'd8, 1, 2'b01);
        #1;
        chk("to_stall_issue", {31'b0, mem_stall}, 32'd1);
        tick();
        for (int k = 1; k <= 4; k++) begin
            if (k < 4) begin
                #1;
                chk("to_stall_wait", {31'b0, mem_stall}, 32'd1);
            end
            tick();
            if (k < 4) chk("to_no_err_yet", {31'b0, bus_err}, 32'd0);
        end
        chk("to_bus_err", {31'b0, bus_err}, 32'd1);
        chk("to_req_drop", {31'b0, dmem_req}, 32'd0);
        chk("to_killed", {30'b0, WB_valid, WB_RegWrite}, 32'd0);
        run_instr(1, 32'h99, 0, 32'h5c, 0, 0, 3'b000, 5'd9, 1, 2'b00, 1, 0);
        chk("to_err_pulse", {31'b0, bus_err}, 32'd0);
        // ack on the 4th WAIT cycle wins over timeout
        run_instr(1, 32'h204, 0, 32'h60, 1, 0, 3'b010, 5'd10, 1, 2'b01, 4, 32'h1357_9BDF);

        // reset asserted mid-WAIT, then a late ack after release
        drive(1, 32'h300, 0, 32'h64, 1, 0, 3'b010, 5'd11, 1, 2'b01);
        tick();
        chk("rw_req", {31'b0, dmem_req}, 32'd1);
        tick();
        rstn = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 3'b0, 5'd0, 1'b0, 2'b0);
        #1;
        chk("rw_req_async", {31'b0, dmem_req}, 32'd0);
        chk("rw_wb_aluout", WB_aluout, 32'd0);
        chk("rw_wb_pc", WB_PC, 32'd0);
        chk("rw_wb_ctl", {30'b0, WB_valid, WB_RegWrite}, 32'd0);
        tick();
        rstn       = 1'b1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("late_ack_stall", {31'b0, mem_stall}, 32'd0);
        tick();
        dmem_ack = 1'b0;
        chk("late_ack_req", {31'b0, dmem_req}, 32'd0);
        chk("late_ack_wb", {30'b0, WB_valid, WB_RegWrite}, 32'd0);
        chk("late_ack_data", WB_Data_in, 32'd0);

        // random mix of ALU ops, loads and stores
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  dmt;
            logic        mr, mw;
            int          kind;
            logic [31:0] addr;
            kind = int'($urandom_range(0, 3));
            mr   = (kind == 1) || (kind == 3);
            mw   = (kind == 2) || (kind == 3);
            addr = $urandom;
            if (mw) dmt = 3'($urandom_range(0, 2));
            else    dmt = 3'($urandom_range(0, 7));
            run_instr(($urandom_range(0, 7) != 0), addr, $urandom, $urandom, mr, mw, dmt,
                      5'($urandom), 1'($urandom), 2'($urandom_range(0, 2)),
                      int'($urandom_range(1, 4)), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage plus the MEM/WB pipeline register of the 5-stage RV32I core.
- Consumes EX/MEM results and issues loads and stores to the data memory over a req/ack handshake.
- Aligns and extends load data, builds store byte-enables, and stalls the pipeline while memory is busy.
- Registered outputs feed the write-back mux directly: WB_aluout, WB_Data_in, WB_PC, WB_WDSel, plus WB_rd and WB_RegWrite.

Parameters:
- BUS_TIMEOUT, 0, number of cycles to wait for dmem_ack before aborting; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- MEM_valid  in  1  instruction present in MEM
- MEM_aluout  in  32  ALU result; effective address for loads and stores
- MEM_rs2data  in  32  store data
- MEM_PC  in  32  instruction PC
- MEM_MemRead  in  1  load
- MEM_MemWrite  in  1  store
- MEM_DMType  in  3  access type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores use 000/001/010
- MEM_WDSel  in  2  write-back select, passed through
- MEM_rd  in  5  destination register
- MEM_RegWrite  in  1  register write enable
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ack  in  1  access complete; dmem_rdata valid this cycle
- dmem_rdata  in  32  read word
- mem_stall  out  1  holds PC, IF/ID, ID/EX and EX/MEM
- misalign_exc  out  1  one-cycle pulse on a misaligned access
- bus_err  out  1  one-cycle pulse on timeout
- WB_valid, WB_aluout[32], WB_Data_in[32], WB_PC[32], WB_WDSel[2], WB_rd[5], WB_RegWrite  out  MEM/WB register

Behaviour:
- Reset (async, rstn=0):
  - State goes to IDLE and the timeout counter clears.
  - All registered outputs clear: dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, misalign_exc, bus_err and all WB_* outputs.
  - dmem_req falls immediately, even mid-transaction. An ack arriving after reset release while in IDLE is ignored.
- Definition: access = MEM_valid & (MEM_MemRead | MEM_MemWrite).
- Misaligned access: half access with addr[0]=1, or word access with addr[1:0]≠0.
- FSM states are IDLE and WAIT.
- IDLE:
  - No access, or a non-memory instruction: no stall. MEM/WB captures the instruction next edge with WB_Data_in=0.
  - Misaligned access:
    - No request is issued and there is no stall.
    - Next edge: misalign_exc=1 and the instruction is killed (WB_valid=0, WB_RegWrite=0).
  - Aligned access:
    - mem_stall=1 combinationally.
    - Next edge: latch dmem_addr, dmem_we, dmem_wdata, dmem_be and the access type; set dmem_req=1; go to WAIT; MEM/WB loads a bubble.
- WAIT:
  - dmem_req and all dmem_* outputs stay stable until ack.
  - mem_stall = ~dmem_ack.
  - On dmem_ack:
    - dmem_req drops next edge; return to IDLE.
    - MEM/WB captures the instruction: WB_Data_in = aligned load data, or 0 for a store.
  - Minimum memory latency: 2 cycles, i.e. 1 stall cycle.
- Timeout (BUS_TIMEOUT>0):
  - Count cycles in WAIT. When the count reaches BUS_TIMEOUT without ack: drop dmem_req, go to IDLE, pulse bus_err, and emit a killed (bubble) WB entry.
  - If ack arrives on the same cycle as the timeout, ack wins.
- Stall bubbles: while mem_stall=1, MEM/WB loads WB_valid=0 and WB_RegWrite=0, so WB never writes twice.
- Stores:
  - Byte: be = 4'b0001<<addr[1:0], wdata = {4{rs2[7:0]}}.
  - Half: be = 4'b0011<<addr[1:0], wdata = {2{rs2[15:0]}}.
  - Word: be = 4'b1111, wdata = rs2.
- Loads:
  - Byte lane is selected by addr[1:0]; half lane by addr[1].
  - Sign-extend for 000/001; zero-extend for 100/101; word passes through.
  - Undefined DMType on a load is treated as lw.
- Simultaneous MemRead and MemWrite: treated as a store.

Decomposition:
- Shared package core_pkg:
  - WDSel encodings (FromALU 00, FromMEM 01, FromPC 10), shared with the write-back stage.
  - DMType encodings.
  - FSM state enum {IDLE, WAIT}.
- One sub-module, mem_load_align (combinational): inputs rdata, addr[1:0], DMType; output is the 32-bit extended load value.
- Store byte-enable and replication logic stays inline.

Test Plan:
- add (MemRead=0), aluout=0x1234 → no stall; next edge WB_aluout=0x1234, WB_valid=1, WB_Data_in=0.
- lb at 0x103, rdata=0x80FF_EEDD, ack after 3 cycles → dmem_addr=0x100, mem_stall high 3 cycles; WB_Data_in=0xFFFFFF80; lbu at the same address gives 0x00000080.
- sh at 0x102, rs2=0xABCD1234 → dmem_be=4'b1100, dmem_wdata=0x12341234, dmem_we=1; WB_RegWrite bubbles during stall.
- lw at 0x101 → no dmem_req; misalign_exc pulses 1 cycle; WB_valid=0; next instruction proceeds without stall.
- BUS_TIMEOUT=4, never ack → bus_err pulse after 4 WAIT cycles; dmem_req=0; FSM in IDLE; then ack coincident with the 4th cycle → normal completion, no bus_err.
- rstn low during WAIT → dmem_req=0 immediately; all WB_* outputs=0; a late ack after release has no effect.
